// File: rtl/mode_pkg.sv
// Mode encodings and controller states shared by the mode controller,
// the flag-bank block and the branch logic.
package mode_pkg;

  localparam logic [1:0] MODE_CLR = 2'b00;
  localparam logic [1:0] MODE_USR = 2'b01;
  localparam logic [1:0] MODE_INT = 2'b10;

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    USER    = 2'd1,
    HANDLER = 2'd2
  } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over up to 8 request lines.
module irq_prio_enc #(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic [2:0]         o_idx,
  output logic               o_valid
);

  always_comb begin
    o_idx = 3'd0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = 3'(i);
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/intr_mode_ctrl.sv
// Mode/interrupt controller: CLEAR -> USER <-> HANDLER, with vectored takes,
// saved return PC and a stall-tolerant return. Mode mirrors the FSM state.
module intr_mode_ctrl
  import mode_pkg::*;
#(
  parameter int                     NUM_IRQ    = 4,
  parameter int                     PC_WIDTH   = 16,
  parameter logic [PC_WIDTH-1:0]    VEC_BASE   = 16'hFF00,
  parameter int                     VEC_STRIDE = 4,
  parameter int                     CLR_CYCLES = 2,
  parameter logic [NUM_IRQ-1:0]     MASK_RST   = '1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic                mask_we,
  input  logic [NUM_IRQ-1:0]  mask_wdata,
  input  logic                stall,
  input  logic [PC_WIDTH-1:0] pc_next,
  input  logic                reti,
  output logic [1:0]          Mode,
  output logic                redirect,
  output logic [PC_WIDTH-1:0] redirect_pc,
  output logic [NUM_IRQ-1:0]  irq_ack,
  output logic [PC_WIDTH-1:0] epc,
  output logic                bad_reti
);

  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  state_t              r_state;
  logic [1:0]          r_mode;
  logic [CW-1:0]       r_clr_cnt;
  logic [NUM_IRQ-1:0]  r_mask;
  logic                r_ret_pend;
  logic                r_redirect;
  logic [PC_WIDTH-1:0] r_redirect_pc;
  logic [NUM_IRQ-1:0]  r_ack;
  logic [PC_WIDTH-1:0] r_epc;
  logic                r_bad_reti;

  logic [NUM_IRQ-1:0]  w_pend;
  logic [2:0]          w_idx;
  logic                w_valid;
  logic [PC_WIDTH-1:0] w_vec;

  // The registered mask is used here, so a same-cycle write does not affect the take.
  assign w_pend = irq & r_mask;

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .i_req   (w_pend),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  assign w_vec = VEC_BASE + PC_WIDTH'(w_idx) * PC_WIDTH'(VEC_STRIDE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= CLEAR;
      r_mode        <= MODE_CLR;
      r_clr_cnt     <= '0;
      r_mask        <= MASK_RST;
      r_ret_pend    <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_ack         <= '0;
      r_epc         <= '0;
      r_bad_reti    <= 1'b0;
    end else begin
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_ack         <= '0;
      if (mask_we) r_mask <= mask_wdata;
      case (r_state)
        CLEAR: begin
          if (reti) r_bad_reti <= 1'b1;
          if (r_clr_cnt == CW'(CLR_CYCLES - 1)) begin
            r_state <= USER;
            r_mode  <= MODE_USR;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        USER: begin
          if (reti) r_bad_reti <= 1'b1;
          if (w_valid && !stall) begin
            r_redirect    <= 1'b1;
            r_redirect_pc <= w_vec;
            r_ack         <= NUM_IRQ'(1) << w_idx;
            r_epc         <= pc_next;
            r_state       <= HANDLER;
            r_mode        <= MODE_INT;
          end
        end
        HANDLER: begin
          // reti is a one-cycle pulse; remember it while the pipeline stalls.
          if ((reti || r_ret_pend) && !stall) begin
            r_redirect    <= 1'b1;
            r_redirect_pc <= r_epc;
            r_ret_pend    <= 1'b0;
            r_state       <= USER;
            r_mode        <= MODE_USR;
          end else if (reti) begin
            r_ret_pend <= 1'b1;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_mode  <= MODE_CLR;
        end
      endcase
    end
  end

  assign Mode        = r_mode;
  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;
  assign irq_ack     = r_ack;
  assign epc         = r_epc;
  assign bad_reti    = r_bad_reti;

endmodule
